id_decode_stage: RTL and testbench

Registered instruction-decode stage of the 32-bit MIPS datapath. It accepts fetched instructions over a valid/ready handshake and splits them into register fields and control bits. It presents the 16-bit immediate together with an extension select to the immediate path. `ext_zero` high routes the immediate through zeroExtender16to32; low routes it through the sign extender. A two-entry skid buffer gives full throughput under downstream back-pressure.

---
 rtl/mips_pkg.sv | 42 ++++
 rtl/id_decoder.sv | 50 +++++
 rtl/id_decode_stage.sv | 107 ++++++++++
 tb/tb_id_decode_stage.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode constants and the decoded-control layout
// used by the decode stage and the execute stage.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Field order is shared with the execute stage; do not reorder.
  typedef struct packed {
    logic ext_zero;
    logic reg_dst;
    logic alu_src_imm;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic branch_ne;
    logic jump;
    logic link;
    logic illegal;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
    ctrl_t       ctrl;
  } entry_t;

endpackage

// File: rtl/id_decoder.sv
// Combinational opcode to control-bundle decoder; no state, zero latency.
// Unknown opcodes raise illegal with every write/mem/branch/jump bit cleared.
module id_decoder
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        ctrl.alu_src_imm = 1'b1;
        ctrl.reg_write   = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctrl.alu_src_imm = 1'b1;
        ctrl.reg_write   = 1'b1;
        ctrl.ext_zero    = 1'b1;
      end
      OP_LW: begin
        ctrl.alu_src_imm = 1'b1;
        ctrl.mem_read    = 1'b1;
        ctrl.reg_write   = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src_imm = 1'b1;
        ctrl.mem_write   = 1'b1;
      end
      OP_BEQ: ctrl.branch = 1'b1;
      OP_BNE: begin
        ctrl.branch    = 1'b1;
        ctrl.branch_ne = 1'b1;
      end
      OP_J: ctrl.jump = 1'b1;
      OP_JAL: begin
        ctrl.jump      = 1'b1;
        ctrl.link      = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_decode_stage.sv
// Registered decode stage with a two-entry head/skid buffer; 1-cycle latency, 1 instr/cycle.
// in_ready is derived from occupancy only, so back-pressure never forms a combinational path.
module id_decode_stage
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc4,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc4,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic [25:0] jaddr,
  output logic        ext_zero,
  output logic        reg_dst,
  output logic        alu_src_imm,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch,
  output logic        branch_ne,
  output logic        jump,
  output logic        link,
  output logic        illegal
);

  entry_t     head;
  entry_t     skid;
  entry_t     incoming;
  ctrl_t      dec_ctrl;
  logic [1:0] cnt;
  logic       accept;
  logic       pop;

  id_decoder u_decoder (
    .opcode (in_instr[31:26]),
    .ctrl   (dec_ctrl)
  );

  assign incoming  = {in_pc4, in_instr, dec_ctrl};
  assign in_ready  = (cnt != 2'(DEPTH));
  assign out_valid = (cnt != 2'd0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head is only rewritten when empty or on a pop, which keeps it stable while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= 2'd0;
      head <= '0;
      skid <= '0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      case ({accept, pop})
        2'b10: begin
          if (cnt == 2'd0) head <= incoming;
          else             skid <= incoming;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          if (cnt == 2'd2) head <= skid;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          // Accept and pop together only happens at cnt==1: new entry becomes head.
          head <= incoming;
        end
        default: ;
      endcase
    end
  end

  assign out_pc4     = head.pc4;
  assign opcode      = head.instr[31:26];
  assign rs          = head.instr[25:21];
  assign rt          = head.instr[20:16];
  assign rd          = head.instr[15:11];
  assign shamt       = head.instr[10:6];
  assign funct       = head.instr[5:0];
  assign imm16       = head.instr[15:0];
  assign jaddr       = head.instr[25:0];
  assign ext_zero    = head.ctrl.ext_zero;
  assign reg_dst     = head.ctrl.reg_dst;
  assign alu_src_imm = head.ctrl.alu_src_imm;
  assign reg_write   = head.ctrl.reg_write;
  assign mem_read    = head.ctrl.mem_read;
  assign mem_write   = head.ctrl.mem_write;
  assign branch      = head.ctrl.branch;
  assign branch_ne   = head.ctrl.branch_ne;
  assign jump        = head.ctrl.jump;
  assign link        = head.ctrl.link;
  assign illegal     = head.ctrl.illegal;

endmodule

// File: tb/tb_id_decode_stage.sv
// Scoreboard bench for id_decode_stage: directed instruction vectors with hand-decoded controls.
module tb_id_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc4;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc4;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic [25:0] jaddr;
  logic        ext_zero, reg_dst, alu_src_imm, reg_write, mem_read, mem_write;
  logic        branch, branch_ne, jump, link, illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_decode_stage #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc4(in_pc4),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc4(out_pc4),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm16(imm16), .jaddr(jaddr), .ext_zero(ext_zero), .reg_dst(reg_dst),
    .alu_src_imm(alu_src_imm), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .branch(branch), .branch_ne(branch_ne), .jump(jump),
    .link(link), .illegal(illegal)
  );

  // {ext_zero, reg_dst, alu_src_imm, reg_write, mem_read, mem_write, branch, branch_ne, jump, link, illegal}
  logic [10:0] act_ctrl;
  assign act_ctrl = {ext_zero, reg_dst, alu_src_imm, reg_write, mem_read, mem_write,
                     branch, branch_ne, jump, link, illegal};

  logic [31:0] v_instr [12];
  logic [10:0] v_ctrl  [12];
  int          sb [$];

  initial begin
    v_instr[0]  = 32'h3508_FFFF; v_ctrl[0]  = 11'b10110000000; // ori
    v_instr[1]  = 32'h2108_FFFF; v_ctrl[1]  = 11'b00110000000; // addi
    v_instr[2]  = 32'h0109_5020; v_ctrl[2]  = 11'b01010000000; // add
    v_instr[3]  = 32'h8D09_0004; v_ctrl[3]  = 11'b00111000000; // lw
    v_instr[4]  = 32'hAD09_0008; v_ctrl[4]  = 11'b00100100000; // sw
    v_instr[5]  = 32'h1109_0003; v_ctrl[5]  = 11'b00000010000; // beq
    v_instr[6]  = 32'h1509_FFFE; v_ctrl[6]  = 11'b00000011000; // bne
    v_instr[7]  = 32'h0800_0010; v_ctrl[7]  = 11'b00000000100; // j
    v_instr[8]  = 32'h0C00_0020; v_ctrl[8]  = 11'b00010000110; // jal
    v_instr[9]  = 32'hFC00_0000; v_ctrl[9]  = 11'b00000000001; // opcode 0x3F
    v_instr[10] = 32'h3C01_1234; v_ctrl[10] = 11'b10110000000; // lui
    v_instr[11] = 32'h2D2A_0010; v_ctrl[11] = 11'b00110000000; // sltiu
  end

  function automatic logic [31:0] pc_of(input int i);
    return 32'h0040_0004 + 32'(i) * 32'd4;
  endfunction

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer vector i until accepted; the expectation is queued at the accepting cycle.
  task automatic send(input int i);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_instr = v_instr[i];
    in_pc4   = pc_of(i);
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(i);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 80'd0, 80'd1);
  endtask

  // Monitor: compare every delivered entry against the queue and watch head stability.
  int          mon_idx;
  logic        hold_pend = 1'b0;
  logic [74:0] hold_snap;
  logic [74:0] cur_snap;
  assign cur_snap = {out_pc4, opcode, rs, rt, rd, shamt, funct, act_ctrl};

  always @(negedge clk) begin
    if (!rst && hold_pend) check("hold_stable", 80'(cur_snap), 80'(hold_snap));
    if (!rst && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 80'(out_pc4), 80'd0);
      end else begin
        mon_idx = sb.pop_front();
        check("out_pc4", 80'(out_pc4), 80'(pc_of(mon_idx)));
        check("fields", 80'({opcode, rs, rt, rd, shamt, funct}), 80'(v_instr[mon_idx]));
        check("imm16", 80'(imm16), 80'(v_instr[mon_idx][15:0]));
        check("jaddr", 80'(jaddr), 80'(v_instr[mon_idx][25:0]));
        check("ctrl", 80'(act_ctrl), 80'(v_ctrl[mon_idx]));
      end
    end
    hold_pend = !rst && !flush && out_valid && !out_ready;
    hold_snap = cur_snap;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc4 = '0; flush = 1'b0; out_ready = 1'b0;
    #3;
    check("rst_out_valid", 80'(out_valid), 80'd0);
    check("rst_in_ready", 80'(in_ready), 80'd1);
    check("rst_cnt", 80'(dut.cnt), 80'd0);
    check("rst_data", 80'(cur_snap), 80'd0);
    check("rst_jaddr_imm", 80'({jaddr, imm16}), 80'd0);
    @(negedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Decode sweep at full throughput.
    out_ready = 1'b1;
    send(0);
    check("lat_out_valid", 80'(out_valid), 80'd1);
    check("ori_rs_rt", 80'({rs, rt}), 80'({5'd8, 5'd8}));
    check("ori_imm16", 80'(imm16), 80'(16'hFFFF));
    check("ori_ctl", 80'({ext_zero, alu_src_imm, reg_write}), 80'(3'b111));
    send(1);
    check("addi_ext_zero", 80'(ext_zero), 80'd0);
    for (int i = 2; i < 12; i++) begin
      send(i);
      check("sustain_in_ready", 80'(in_ready), 80'd1);
    end
    repeat (2) @(posedge clk);
    #1 check("sweep_drain", 80'(sb.size()), 80'd0);

    // Back-pressure: four offered with out_ready low, then released.
    out_ready = 1'b0;
    fork
      begin
        send(3); send(4); send(5); send(6);
      end
      begin
        repeat (2) @(posedge clk);
        #2;
        check("bp_in_ready", 80'(in_ready), 80'd0);
        check("bp_cnt", 80'(dut.cnt), 80'd2);
        repeat (3) @(posedge clk);
        #2;
        check("bp_still_full", 80'({in_ready, out_valid}), 80'(2'b01));
        out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1 check("bp_drain", 80'(sb.size()), 80'd0);

    // Accept and pop in the same cycle at cnt==1.
    out_ready = 1'b0;
    send(10);
    out_ready = 1'b1;
    send(11);
    check("simul_cnt", 80'(dut.cnt), 80'd1);
    check("simul_head", 80'({out_valid, opcode}), 80'({1'b1, 6'h0B}));
    repeat (2) @(posedge clk);
    #1 check("simul_drain", 80'(sb.size()), 80'd0);

    // Flush while full with an instruction offered.
    out_ready = 1'b0;
    send(4); send(5);
    in_valid = 1'b1; in_instr = v_instr[6]; in_pc4 = pc_of(6); flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; sb.delete();
    check("flush_full_state", 80'({out_valid, dut.cnt, in_ready}), 80'(4'b0001));
    out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;

    // Flush at cnt==1 with an acceptable input and a ready consumer: nothing survives.
    out_ready = 1'b0;
    send(7);
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = v_instr[8]; in_pc4 = pc_of(8); flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; sb.delete();
    check("flush_one_state", 80'({out_valid, dut.cnt}), 80'd0);
    repeat (3) @(posedge clk); #1;
    send(9);
    repeat (2) @(posedge clk);
    #1 check("post_flush_drain", 80'(sb.size()), 80'd0);

    // Asynchronous reset in the middle of a full buffer.
    out_ready = 1'b0;
    send(2); send(3);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 80'(out_valid), 80'd0);
    check("arst_in_ready", 80'(in_ready), 80'd1);
    check("arst_cnt", 80'(dut.cnt), 80'd0);
    check("arst_data", 80'(cur_snap), 80'd0);
    sb.delete();
    @(negedge clk); #1 rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
